pq_keccak_round_seq: RTL and testbench
======================================

// Module: pq_keccak_round_seq
// PURPOSE
//  Sequencer directly upstream of the ID-stage Keccak datapath.
//  Turns one decoded Keccak-f[1600] instruction into one accelerator drive step per round cycle,
//  with one round per cycle while not stalled.
//  Drives the keccak_f_start, keccak_round and keccak_rst inputs of the accelerator wrapper.
//  Holds the core while the permutation runs.
// PARAMETERS
//  NUM_ROUNDS  24  rounds per permutation (Keccak-f[1600]); legal 1..32
//  ROUND_W     5   width of round index; must satisfy 2**ROUND_W >= NUM_ROUNDS
// PORTS
//  clk               in   1        clock, rising edge
//  rst_n             in   1        reset, asynchronous, active-low
//  start_i           in   1        decoder: Keccak-f instruction issued (level, sampled each clk)
//  stall_i           in   1        pipeline stall; freezes round progress
//  abort_i           in   1        pipeline flush; cancels permutation
//  busy_o            out  1        permutation in progress (INIT or ROUND)
//  core_halt_o       out  1        stall request to ID stage; equals busy_o
//  done_o            out  1        1-cycle pulse after last round written
//  keccak_rst_o      out  1        1-cycle state-init strobe to datapath
//  keccak_f_start_o  out  1        round write enable (PQ regfile + GP regs)
//  keccak_round_o    out  ROUND_W  round index driven to round-constant logic
//  perm_count_o      out  32       completed permutations (see CONFIGURATION)
//  stall_cycles_o    out  32       ROUND cycles lost to stall_i (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0. State resets to IDLE.
//  - FSM states: IDLE -> INIT -> ROUND -> DONE -> IDLE.
//  - IDLE: start_i=1 and abort_i=0 -> INIT.
//  - INIT: keccak_rst_o=1 for exactly one cycle; round counter cleared; next state ROUND.
//  - ROUND, stall_i=0: keccak_f_start_o=1 and keccak_round_o=count.
//    count increments each cycle; after count==NUM_ROUNDS-1 the next state is DONE.
//  - ROUND, stall_i=1: keccak_f_start_o=0; count and keccak_round_o hold; no regfile write.
//  - DONE: done_o=1 for one cycle, busy_o=0; next state IDLE.
//  - Latency: start accepted at edge E.
//    - INIT is cycle E+1.
//    - Rounds 0..NUM_ROUNDS-1 occupy cycles E+2..E+NUM_ROUNDS+1 when there are no stalls.
//    - done_o is at E+NUM_ROUNDS+2 (E+26 for 24 rounds).
//    - Each stalled ROUND cycle adds one cycle.
//  - busy_o and core_halt_o are 1 in INIT and ROUND only.
//  - start_i while not IDLE: ignored; no queueing.
//  - start_i in DONE: ignored; a new start is needed in IDLE.
//  - abort_i in any state: next state IDLE; all strobes 0 from the next cycle; no done_o.
//    abort_i has priority over start_i and stall_i.
//  - stall_i in INIT: INIT holds; keccak_rst_o stays 1 while held.
//    The datapath init is idempotent.
//  - rst_n mid-operation: immediate IDLE; all outputs 0 asynchronously; counters cleared.
//  - keccak_round_o is 0 outside ROUND; the count never exceeds NUM_ROUNDS-1.
// CONFIGURATION
//  - Macro: PQ_KECCAK_SEQ_PERF_EN.
//  - Defined:
//    - perm_count_o increments, wrapping at 2**32, on each DONE cycle.
//    - stall_cycles_o increments, saturating at 32'hffffffff, on each ROUND cycle with stall_i=1.
//    - Both are cleared only by rst_n.
//  - Undefined: both ports tied to 32'h0; no counter flops synthesized.
// STRUCTURE
//  - pq_keccak_seq_pkg holds:
//    - typedef enum logic [1:0] {KS_IDLE, KS_INIT, KS_ROUND, KS_DONE} keccak_seq_state_t;
//    - localparam KECCAK_NUM_ROUNDS=24;
//    - localparam KECCAK_ROUND_W=5.
//  - Single module: one FSM always_ff, one round-counter always_ff, optional perf always_ff.
//  - No sub-module.
// TESTING
//  - Basic run: start_i pulse at cycle 0, no stalls.
//    keccak_rst_o at cycle 1; keccak_f_start_o=1 at cycles 2..25 with rounds 0..23; done_o at cycle 26.
//  - Stall: stall_i=1 on cycles 5..7.
//    Round 3 held and f_start=0 on those cycles; done_o at cycle 29.
//    With the macro defined, stall_cycles_o=3.
//  - Abort: abort_i at round 10.
//    Next cycle busy_o=0, no done_o.
//    A start 2 cycles later rearms: INIT, then round 0.
//  - Start while busy: start_i held high for 40 cycles from cycle 0.
//    First permutation completes with done_o at 26; the second starts from IDLE at cycle 27.
//  - Reset: rst_n low at round 12.
//    All outputs 0 immediately; after release the FSM is in IDLE and keccak_round_o=0.
//  - Perf: 3 back-to-back permutations with the macro defined gives perm_count_o=3.
//    With the macro undefined, both perf ports read 0.

Source files
------------

// File: rtl/pq_keccak_round_seq_pkg.sv
// Shared types and defaults for the Keccak-f[1600] round sequencer.
// Contents: sequencer state encoding, default round count and round-index width.
// Imported by the sequencer interface and the sequencer module.
package pq_keccak_seq_pkg;

   typedef enum logic [1:0] {KS_IDLE, KS_INIT, KS_ROUND, KS_DONE} keccak_seq_state_t;

   localparam int KECCAK_NUM_ROUNDS = 24;
   localparam int KECCAK_ROUND_W    = 5;

endpackage

// File: rtl/pq_keccak_round_seq_if.sv
// Handshake/status bundle between the ID stage and the Keccak round sequencer.
// master: decoder/pipeline side (drives start/stall/abort, observes status and strobes).
// slave : sequencer side (consumes start/stall/abort, drives strobes, round index, perf counters).
interface pq_keccak_round_seq_if
   import pq_keccak_seq_pkg::*;
#(
   parameter int ROUND_W = KECCAK_ROUND_W
);

   logic               start_i;
   logic               stall_i;
   logic               abort_i;
   logic               busy_o;
   logic               core_halt_o;
   logic               done_o;
   logic               keccak_rst_o;
   logic               keccak_f_start_o;
   logic [ROUND_W-1:0] keccak_round_o;
   logic [31:0]        perm_count_o;
   logic [31:0]        stall_cycles_o;

   modport master (
      output start_i, stall_i, abort_i,
      input  busy_o, core_halt_o, done_o, keccak_rst_o, keccak_f_start_o,
      input  keccak_round_o, perm_count_o, stall_cycles_o
   );

   modport slave (
      input  start_i, stall_i, abort_i,
      output busy_o, core_halt_o, done_o, keccak_rst_o, keccak_f_start_o,
      output keccak_round_o, perm_count_o, stall_cycles_o
   );

endinterface

// File: rtl/pq_keccak_round_seq.sv
// Sequences one Keccak-f[1600] instruction into an init strobe plus NUM_ROUNDS round writes.
// Ports: clk, rst_n (async, active-low), sif (slave side: start/stall/abort in; busy,
//   core_halt, done, keccak_rst, keccak_f_start, keccak_round, perf counters out).
// All outputs registered. Optional perf counters enabled by macro PQ_KECCAK_SEQ_PERF_EN.
module pq_keccak_round_seq
   import pq_keccak_seq_pkg::*;
#(
   parameter int NUM_ROUNDS = KECCAK_NUM_ROUNDS,
   parameter int ROUND_W    = KECCAK_ROUND_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pq_keccak_round_seq_if.slave sif
);

   localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS - 1);

   keccak_seq_state_t  state_q, state_d;
   logic [ROUND_W-1:0] cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               krst_q, krst_d;
   logic               fstart_q, fstart_d;

   // cnt holds the index of the most recently written round while in ROUND,
   // so a stalled cycle naturally re-presents it with the write enable low.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fstart_d = 1'b0;
      if (sif.abort_i) begin
         state_d = KS_IDLE;
      end else begin
         case (state_q)
            KS_IDLE: begin
               if (sif.start_i) state_d = KS_INIT;
            end
            KS_INIT: begin
               // Stalled init simply repeats the (idempotent) init strobe.
               if (!sif.stall_i) begin
                  state_d  = KS_ROUND;
                  cnt_d    = '0;
                  fstart_d = 1'b1;
               end
            end
            KS_ROUND: begin
               // Last round already written: finish even if a stall arrives now.
               if (cnt_q == LAST_RND) begin
                  state_d = KS_DONE;
               end else if (!sif.stall_i) begin
                  cnt_d    = cnt_q + ROUND_W'(1);
                  fstart_d = 1'b1;
               end
            end
            KS_DONE: begin
               state_d = KS_IDLE;
            end
            default: begin
               state_d = KS_IDLE;
            end
         endcase
      end
      // Round index is only meaningful in ROUND; keep it at zero elsewhere.
      if (state_d != KS_ROUND) cnt_d = '0;
      busy_d = (state_d == KS_INIT) || (state_d == KS_ROUND);
      done_d = (state_d == KS_DONE);
      krst_d = (state_d == KS_INIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= KS_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         krst_q   <= 1'b0;
         fstart_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         krst_q   <= krst_d;
         fstart_q <= fstart_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign sif.busy_o           = busy_q;
   assign sif.core_halt_o      = busy_q;
   assign sif.done_o           = done_q;
   assign sif.keccak_rst_o     = krst_q;
   assign sif.keccak_f_start_o = fstart_q;
   assign sif.keccak_round_o   = cnt_q;

`ifdef PQ_KECCAK_SEQ_PERF_EN
   logic [31:0] perm_cnt_q, perm_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      perm_cnt_d  = perm_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (state_q == KS_DONE) perm_cnt_d = perm_cnt_q + 32'd1;
      if ((state_q == KS_ROUND) && sif.stall_i && (stall_cnt_q != 32'hffff_ffff))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perm_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         perm_cnt_q  <= perm_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign sif.perm_count_o   = perm_cnt_q;
   assign sif.stall_cycles_o = stall_cnt_q;
`else
   assign sif.perm_count_o   = 32'h0;
   assign sif.stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pq_keccak_round_seq.sv
// Testbench for pq_keccak_round_seq: directed scenarios plus random traffic.
// A permutation-level reference model predicts every cycle's outputs into a queue;
// an independent monitor pops and compares after each rising edge.
module tb_pq_keccak_round_seq;
   import pq_keccak_seq_pkg::*;

   localparam int N  = KECCAK_NUM_ROUNDS;
   localparam int RW = KECCAK_ROUND_W;
`ifdef PQ_KECCAK_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pq_keccak_round_seq_if #(.ROUND_W(RW)) sif ();

   pq_keccak_round_seq #(.NUM_ROUNDS(N), .ROUND_W(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit      busy;
      bit      done;
      bit      krst;
      bit      fst;
      int      rnd;
      longint  perm;
      longint  stl;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_done = -1;
   int   done_cnt  = 0;

   // Reference model: a permutation in flight, whether its init is still pending,
   // how many rounds have been written, and whether this cycle is the done pulse.
   bit     m_active, m_init, m_done, m_wrote;
   int     m_written;
   longint m_perm, m_stl;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_active = 0; m_init = 0; m_done = 0; m_wrote = 0;
      m_written = 0; m_perm = 0; m_stl = 0;
   endfunction

   function automatic void model_step(bit st, bit sl, bit ab);
      bit in_rounds = m_active && !m_init;
      bit was_done  = m_done;
      if (was_done) m_perm = (m_perm + 1) % (64'd1 << 32);
      if (in_rounds && sl && m_stl < 64'hffff_ffff) m_stl++;
      m_wrote = 0;
      m_done  = 0;
      if (ab) begin
         m_active = 0; m_init = 0; m_written = 0;
      end else if (was_done) begin
         // cycle after done always returns to idle; start here is dropped
      end else if (!m_active) begin
         if (st) begin m_active = 1; m_init = 1; m_written = 0; end
      end else if (m_init) begin
         if (!sl) begin m_init = 0; m_written = 1; m_wrote = 1; end
      end else if (m_written == N) begin
         m_active = 0; m_done = 1; m_written = 0;
      end else if (!sl) begin
         m_written++; m_wrote = 1;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.busy = m_active;
      e.done = m_done;
      e.krst = m_active && m_init;
      e.fst  = m_wrote;
      e.rnd  = (m_active && !m_init) ? m_written - 1 : 0;
      e.perm = PERF ? m_perm : 0;
      e.stl  = PERF ? m_stl  : 0;
      return e;
   endfunction

   task automatic cycle(input bit st, input bit sl, input bit ab);
      @(negedge clk);
      rst_n       = 1'b1;
      sif.start_i = st;
      sif.stall_i = sl;
      sif.abort_i = ab;
      model_step(st, sl, ab);
      exp_q.push_back(model_out());
      cyc++;
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n       = 1'b0;
         sif.start_i = 1'b0;
         sif.stall_i = 1'b0;
         sif.abort_i = 1'b0;
         if (i == 0) begin
            #1;
            chk("async_rst_busy",   sif.busy_o,           0);
            chk("async_rst_halt",   sif.core_halt_o,      0);
            chk("async_rst_fstart", sif.keccak_f_start_o, 0);
            chk("async_rst_krst",   sif.keccak_rst_o,     0);
            chk("async_rst_round",  sif.keccak_round_o,   0);
            chk("async_rst_perm",   sif.perm_count_o,     0);
            chk("async_rst_stall",  sif.stall_cycles_o,   0);
         end
         model_reset();
         exp_q.push_back(model_out());
         cyc++;
      end
   endtask

   // Monitor: every rising edge that has a prediction gets compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy_o",           sif.busy_o,           e.busy);
            chk("core_halt_o",      sif.core_halt_o,      e.busy);
            chk("done_o",           sif.done_o,           e.done);
            chk("keccak_rst_o",     sif.keccak_rst_o,     e.krst);
            chk("keccak_f_start_o", sif.keccak_f_start_o, e.fst);
            chk("keccak_round_o",   sif.keccak_round_o,   e.rnd);
            chk("perm_count_o",     sif.perm_count_o,     e.perm);
            chk("stall_cycles_o",   sif.stall_cycles_o,   e.stl);
            if (sif.done_o) begin
               last_done = cyc;
               done_cnt++;
            end
         end
      end
   end

   initial begin
      int s;
      sif.start_i = 1'b0;
      sif.stall_i = 1'b0;
      sif.abort_i = 1'b0;
      model_reset();

      // Reset state
      reset_cycles(3);

      // Basic run: done 26 cycles after the start cycle
      last_done = -1;
      s = cyc;
      cycle(1, 0, 0);
      repeat (30) cycle(0, 0, 0);
      chk("basic_done_latency", last_done - s, 26);

      // Stall on cycles 5..7: three extra cycles, three lost ROUND cycles
      reset_cycles(2);
      last_done = -1;
      s = cyc;
      cycle(1, 0, 0);
      for (int i = 1; i < 34; i++) cycle(0, (i >= 5 && i <= 7), 0);
      chk("stall_done_latency", last_done - s, 29);
      chk("stall_cycles_count", sif.stall_cycles_o, PERF ? 3 : 0);

      // Abort mid-permutation: no done, then a fresh start rearms
      last_done = -1;
      cycle(1, 0, 0);
      repeat (11) cycle(0, 0, 0);
      cycle(0, 0, 1);
      repeat (2) cycle(0, 0, 0);
      chk("abort_no_done", last_done, -1);
      s = cyc;
      cycle(1, 0, 0);
      repeat (28) cycle(0, 0, 0);
      chk("rearm_done_latency", last_done - s, 26);

      // Start held for 40 cycles: second permutation starts only from IDLE
      reset_cycles(1);
      last_done = -1;
      done_cnt  = 0;
      s = cyc;
      repeat (40) cycle(1, 0, 0);
      repeat (20) cycle(0, 0, 0);
      chk("held_start_done_count", done_cnt, 2);
      chk("held_start_second_done", last_done - s, 2 * 26 + 1);

      // Reset in the middle of the rounds
      cycle(1, 0, 0);
      repeat (13) cycle(0, 0, 0);
      reset_cycles(2);
      repeat (4) cycle(0, 0, 0);

      // Three back-to-back permutations
      reset_cycles(1);
      repeat (60) cycle(1, 0, 0);
      repeat (30) cycle(0, 0, 0);
      chk("perf_perm_count", sif.perm_count_o, PERF ? 3 : 0);
      chk("perf_stall_zero", sif.stall_cycles_o, 0);

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 799) == 0) begin
            reset_cycles($urandom_range(1, 3));
         end else begin
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 59) == 0);
         end
      end

      @(posedge clk);
      #3;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
